// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: fetch-queue RAM, redirect and issue signals; fetch_fault_o only with FETCH_BOUNDS_CHECK_EN
interface inst_fetch_queue_if;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic        fetch_fault_o;
  modport master (
    output imem_addr_o, inst_valid_o, inst_o, inst_pc_o, fetch_fault_o,
    input  imem_data_i, redirect_i, redirect_pc_i, inst_ready_i
  );
  modport slave (
    input  imem_addr_o, inst_valid_o, inst_o, inst_pc_o, fetch_fault_o,
    output imem_data_i, redirect_i, redirect_pc_i, inst_ready_i
  );
`else
  modport master (
    output imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
    input  imem_data_i, redirect_i, redirect_pc_i, inst_ready_i
  );
  modport slave (
    input  imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
    output imem_data_i, redirect_i, redirect_pc_i, inst_ready_i
  );
`endif
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetches from a combinational RAM into a {pc,instr} FIFO; FETCH_BOUNDS_CHECK_EN adds the fetch fault
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          IMEM_WORDS  = 32838
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_queue_if.master  bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(QUEUE_DEPTH);
  logic [31:0]   pc_q, pc_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0]   pc_mem_q  [QUEUE_DEPTH];
  logic [31:0]   ins_mem_q [QUEUE_DEPTH];
  logic          valid, pop, push, oor;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic fault_q;
  assign oor = pc_q[31:2] >= 30'(IMEM_WORDS);
  assign bus.fetch_fault_o = fault_q | oor;
  // sticky fault, cleared only by redirect or reset
  always_ff @(posedge clk)
    fault_q <= (rst | bus.redirect_i) ? 1'b0 : (fault_q | oor);
`else
  assign oor = 1'b0 && IMEM_WORDS > 0;
`endif
  assign valid            = count_q != '0;
  assign pop              = valid & bus.inst_ready_i;
  assign push             = !bus.redirect_i & (count_q != FULL | pop) & !oor;
  assign bus.imem_addr_o  = pc_q;
  assign bus.inst_valid_o = valid;
  assign bus.inst_o       = valid ? ins_mem_q[rd_q] : '0;
  assign bus.inst_pc_o    = valid ? pc_mem_q[rd_q] : '0;
  // next-state: redirect flushes and restarts, otherwise advance on push/pop
  always_comb begin
    pc_d    = bus.redirect_i ? {bus.redirect_pc_i[31:2], 2'b00} : push ? pc_q + 32'd4 : pc_q;
    count_d = bus.redirect_i ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    rd_d    = bus.redirect_i ? '0 : rd_q + AW'(pop);
    wr_d    = bus.redirect_i ? '0 : wr_q + AW'(push);
  end
  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end
  // queue storage, written with the word fetched at pc_q
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem_q[wr_q]  <= pc_q;
      ins_mem_q[wr_q] <= bus.imem_data_i;
    end
  end
endmodule
